modbus_uart_rx: RTL and testbench
=================================

# modbus_uart_rx

Serial receiver stage directly upstream of the Modbus-to-Wishbone bridge. Deserialises the RS-485 RX line into 8-bit characters with optional parity, flags first-of-frame characters, and detects the Modbus RTU 3.5-character inter-frame silence. Holds one received character in a single-entry register, consumed by the bridge via a one-cycle request pulse.

## Interface
- `BAUD_DIV`, 868: clock cycles per bit; minimum 8.
- `PARITY`, 2: 0 = none, 1 = odd, 2 = even.
- `SILENCE_BITS`, 39: idle bit-times after a stop-bit sample that define frame end (3.5 chars × 11 bits, rounded up).

- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rx`  in  1: asynchronous serial line, idle high.
- `dataIn`  out  9: [7:0] character, LSB first on the line; [8] = first character after silence.
- `dataReceived`  out  1: holding register valid (level).
- `parityError`  out  1: held character had a parity or framing (stop = 0) error.
- `overflow`  out  1: at least one character was dropped while the holding register was full.
- `silence`  out  1: line idle for ≥ SILENCE_BITS bit-times (level).
- `receiveReq`  in  1: one-cycle pulse from the consumer; releases the holding register.

## Operation
- `rx` passes through a 2-flop synchroniser; all decisions use the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on `rxs` → START, bit counter := 0.
  - START: sample at BAUD_DIV/2 (floor). `rxs`=1 → IDLE (false start, nothing stored). Otherwise → DATA.
  - DATA: 8 samples, each BAUD_DIV apart, shifted in LSB first → PARITY if PARITY≠0, else STOP.
  - PARITY: one sample; error if the data+parity XOR is 0 for odd or 1 for even.
  - STOP: one sample; `rxs`=0 is a framing error. Character completes here → IDLE. Does not wait for the line to return high; a new falling edge is accepted only after `rxs` is seen high.
- Completion with the holding register empty: load `dataIn`[7:0], `dataIn`[8] := first-flag, `parityError` := parity | framing; set `dataReceived`.
- Completion with the holding register full: discard the new character, set `overflow`, and leave the held contents unchanged.
- `receiveReq` while `dataReceived`=1: clear `dataReceived`, `overflow` and `parityError`. `dataIn` keeps its value.
- `receiveReq` while `dataReceived`=0: ignored.
- Completion and `receiveReq` in the same cycle: the request releases the old character and the new one loads. `overflow` := 0, `dataReceived` stays 1.
- Silence counter: cleared at each stop-bit sample and at START entry. Increments per clock while in IDLE, saturating at SILENCE_BITS × BAUD_DIV. `silence` = 1 while the counter is at saturation; it drops in the cycle START is entered.
- First-flag: set while `silence`=1, captured into `dataIn`[8] at completion, cleared after each completed character.

## Timing
- Reset values: `dataIn`=0, `dataReceived`=0, `parityError`=0, `overflow`=0, `silence`=0, FSM=IDLE, silence counter=0, first-flag=1.
- After reset with the line idle, `silence` rises SILENCE_BITS × BAUD_DIV cycles after reset release.
- Latency: `dataReceived` rises 1 cycle after the stop-bit sample. The stop-bit sample is ≈ (9.5 + P) × BAUD_DIV + 2 synchroniser cycles after the start edge, where P = 1 if PARITY≠0, else 0.
- `dataReceived`, `dataIn`, `parityError` and `overflow` change only on completion or on an accepted `receiveReq`, and are registered.
- Reset asserted mid-character: everything returns to reset values immediately and the partial character is lost.

## Test plan
- BAUD_DIV=16, PARITY=2: after 39×16 idle cycles, send 0x25 with even parity bit 1. Expect `dataIn`=0x125, `dataReceived`=1, `parityError`=0, `silence` drops at START.
- Send 0x25 then 0x03 back-to-back with no `receiveReq`. Expect `dataIn`[7:0]=0x25 held, `overflow`=1. A `receiveReq` pulse clears `dataReceived` and `overflow`.
- Send 0x03 with a wrong parity bit, and separately a byte with stop=0. Expect `parityError`=1 each time, cleared by `receiveReq`.
- Glitch `rx` low for 4 cycles. Expect no character, FSM back in IDLE, and the silence counter restarted.
- Two characters 1 bit-time apart, each consumed by `receiveReq`. Expect `dataIn`[8]=1 then 0. `silence` stays 0 until 39 bit-times after the second stop sample.
- Assert `rst` during DATA. Expect all outputs 0 at once, and a clean reception of the next character after `silence`.

Source files
------------

// File: rtl/modbus_uart_rx_if.sv
// Character interface between the Modbus RTU serial receiver and its consumer.
//   rx           : raw RS-485 receive line (idle high)
//   dataIn       : [7:0] character, [8] first character after inter-frame silence
//   dataReceived : holding register valid
//   parityError  : held character had a parity or framing error
//   overflow     : a character was dropped while the holding register was full
//   silence      : line idle for at least the inter-frame silence time
//   receiveReq   : one-cycle pulse from the consumer releasing the holding register
interface modbus_uart_rx_if;
  logic       rx;
  logic [8:0] dataIn;
  logic       dataReceived;
  logic       parityError;
  logic       overflow;
  logic       silence;
  logic       receiveReq;

  // Receiver side
  modport master (
    input  rx,
    input  receiveReq,
    output dataIn,
    output dataReceived,
    output parityError,
    output overflow,
    output silence
  );

  // Line driver / consumer side
  modport slave (
    output rx,
    output receiveReq,
    input  dataIn,
    input  dataReceived,
    input  parityError,
    input  overflow,
    input  silence
  );
endinterface

// File: rtl/modbus_uart_rx.sv
// Modbus RTU serial receiver: deserialises the RX line into 8-bit characters with
// optional parity, flags the first character after the 3.5-character silence and
// holds one character until the consumer releases it with receiveReq.
//   clk  : clock, all logic on rising edge
//   rst  : asynchronous active-high reset
//   bus  : modbus_uart_rx_if.master (rx, receiveReq in; dataIn, dataReceived,
//          parityError, overflow, silence out)
module modbus_uart_rx #(
  parameter int unsigned BAUD_DIV     = 868,
  parameter int unsigned PARITY       = 2,
  parameter int unsigned SILENCE_BITS = 39
) (
  input  logic             clk,
  input  logic             rst,
  modbus_uart_rx_if.master bus
);

  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned SIL_MAX  = SILENCE_BITS * BAUD_DIV;
  localparam int unsigned SIL_W    = $clog2(SIL_MAX + 1);
  localparam bit          PAR_EN   = (PARITY != 0);
  localparam bit          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rxs_q, rxs_prev_q;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_err_q, par_err_d;
  logic [SIL_W-1:0]   sil_cnt_q, sil_cnt_d;
  logic               silence_q, silence_d;
  logic               first_q, first_d;
  logic [8:0]         data_q, data_d;
  logic               dr_q, dr_d;
  logic               perr_q, perr_d;
  logic               ovf_q, ovf_d;
  logic               stop_sample;
  logic               start_entry;
  logic               baud_tick;
  logic               half_tick;

  // State registers; synchroniser resets to idle-high so reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      sil_cnt_q  <= '0;
      silence_q  <= 1'b0;
      first_q    <= 1'b1;
      data_q     <= '0;
      dr_q       <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      sil_cnt_q  <= sil_cnt_d;
      silence_q  <= silence_d;
      first_q    <= first_d;
      data_q     <= data_d;
      dr_q       <= dr_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign baud_tick = (baud_q == CNT_W'(BAUD_DIV - 1));
  assign half_tick = (baud_q == CNT_W'(HALF_DIV));

  // Next-state: bit sequencing, silence timing and holding register
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    sil_cnt_d   = sil_cnt_q;
    first_d     = first_q;
    data_d      = data_q;
    dr_d        = dr_q;
    perr_d      = perr_q;
    ovf_d       = ovf_q;
    stop_sample = 1'b0;
    start_entry = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Edge detect on the synchronised line also enforces "seen high" after a low stop bit
        if (rxs_prev_q && !rxs_q) begin
          state_d     = S_START;
          baud_d      = '0;
          bit_d       = '0;
          par_err_d   = 1'b0;
          start_entry = 1'b1;
        end
      end
      S_START: begin
        baud_d = baud_q + CNT_W'(1);
        if (half_tick) begin
          baud_d  = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d    = '0;
          // Even: error when XOR of data+parity is 1; odd: error when it is 0
          par_err_d = (^shift_q) ^ rxs_q ^ PAR_ODD;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_tick) begin
          baud_d      = '0;
          stop_sample = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-frame silence counter, saturating while the receiver sits in IDLE
    if (start_entry || stop_sample) begin
      sil_cnt_d = '0;
    end else if (state_q == S_IDLE && sil_cnt_q != SIL_W'(SIL_MAX)) begin
      sil_cnt_d = sil_cnt_q + SIL_W'(1);
    end
    silence_d = (sil_cnt_d == SIL_W'(SIL_MAX));

    if (stop_sample) begin
      first_d = 1'b0;
    end else if (silence_q) begin
      first_d = 1'b1;
    end

    // Holding register: a same-cycle request frees the slot for the new character
    if (stop_sample) begin
      if (!dr_q || bus.receiveReq) begin
        data_d = {first_q, shift_q};
        perr_d = par_err_q | ~rxs_q;
        dr_d   = 1'b1;
        ovf_d  = 1'b0;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (bus.receiveReq && dr_q) begin
      dr_d   = 1'b0;
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end
  end

  assign bus.dataIn       = data_q;
  assign bus.dataReceived = dr_q;
  assign bus.parityError  = perr_q;
  assign bus.overflow     = ovf_q;
  assign bus.silence      = silence_q;

endmodule

// File: tb/tb_modbus_uart_rx.sv
// Self-checking bench for modbus_uart_rx: directed scenarios plus randomised
// characters checked against a character-level model of the holding register.
module tb_modbus_uart_rx;

  localparam int unsigned BD  = 16;
  localparam int unsigned PAR = 2;
  localparam int unsigned SB  = 39;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  modbus_uart_rx_if bus_if ();

  modbus_uart_rx #(
    .BAUD_DIV    (BD),
    .PARITY      (PAR),
    .SILENCE_BITS(SB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Character-level model of the consumer-visible state
  logic [8:0] m_data;
  bit         m_dr;
  bit         m_perr;
  bit         m_ovf;
  bit         m_first;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, bus_if.dataIn, m_data);
    check({tag, "_dr"},   9'(bus_if.dataReceived), 9'(m_dr));
    check({tag, "_perr"}, 9'(bus_if.parityError), 9'(m_perr));
    check({tag, "_ovf"},  9'(bus_if.overflow), 9'(m_ovf));
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_dr    = 1'b0;
    m_perr  = 1'b0;
    m_ovf   = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic model_complete(input logic [7:0] b, input bit err);
    if (!m_dr) begin
      m_data = {m_first, b};
      m_perr = err;
      m_dr   = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      m_ovf  = 1'b1;
    end
    m_first = 1'b0;
  endtask

  task automatic do_req();
    bus_if.receiveReq = 1'b1;
    tick(1);
    bus_if.receiveReq = 1'b0;
    if (m_dr) begin
      m_dr   = 1'b0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end
  endtask

  // Drive one full frame: start, 8 data LSB first, parity, stop
  task automatic send_char(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic pbit;
    bus_if.rx = 1'b0;
    tick(BD);
    check("silence_in_start", 9'(bus_if.silence), 9'd0);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx = b[i];
      tick(BD);
    end
    if (PAR != 0) begin
      pbit = (PAR == 2) ? (^b) : ~(^b);
      bus_if.rx = pbit ^ par_bad;
      tick(BD);
    end
    bus_if.rx = ~stop_bad;
    tick(BD);
    bus_if.rx = 1'b1;
    tick(2);
  endtask

  logic [7:0] rb;
  bit         rpb, rsb, rlong, rcons;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.rx         = 1'b1;
    bus_if.receiveReq = 1'b0;
    model_reset();
    tick(3);

    // Reset state
    check_all("reset");
    check("reset_silence", 9'(bus_if.silence), 9'd0);
    rst = 1'b0;

    // Silence rises SB*BD cycles after reset release
    tick(SB * BD - 4);
    check("silence_before", 9'(bus_if.silence), 9'd0);
    tick(10);
    check("silence_after", 9'(bus_if.silence), 9'd1);

    // First character after silence: 0x25 with even parity bit 1
    send_char(8'h25, 1'b0, 1'b0);
    model_complete(8'h25, 1'b0);
    check("first_char_value", bus_if.dataIn, 9'h125);
    check_all("first_char");

    // Back-to-back without release: new character dropped, overflow set
    send_char(8'h03, 1'b0, 1'b0);
    model_complete(8'h03, 1'b0);
    check("ovf_held_byte", 9'(bus_if.dataIn[7:0]), 9'h025);
    check_all("overflow");
    do_req();
    check_all("overflow_release");
    check("release_keeps_data", bus_if.dataIn, 9'h125);

    // Wrong parity bit
    tick(8);
    send_char(8'h03, 1'b1, 1'b0);
    model_complete(8'h03, 1'b1);
    check_all("parity_err");
    do_req();
    check_all("parity_err_clear");

    // Framing error (stop bit low)
    tick(8);
    send_char(8'hA5, 1'b0, 1'b1);
    model_complete(8'hA5, 1'b1);
    check_all("frame_err");
    do_req();
    check_all("frame_err_clear");

    // Glitch after silence: no character, silence counter restarts
    tick(42 * BD);
    check("pre_glitch_silence", 9'(bus_if.silence), 9'd1);
    m_first = 1'b1;
    bus_if.rx = 1'b0;
    tick(4);
    bus_if.rx = 1'b1;
    tick(20);
    check("glitch_silence_drop", 9'(bus_if.silence), 9'd0);
    check_all("glitch");
    tick(580);
    check("glitch_silence_early", 9'(bus_if.silence), 9'd0);
    tick(76);
    check("glitch_silence_back", 9'(bus_if.silence), 9'd1);

    // Two characters one bit-time apart: first flag 1 then 0
    send_char(8'h5A, 1'b0, 1'b0);
    model_complete(8'h5A, 1'b0);
    check("pair_first_flag", 9'(bus_if.dataIn[8]), 9'd1);
    check_all("pair_a");
    do_req();
    tick(BD - 1);
    send_char(8'hC3, 1'b0, 1'b0);
    model_complete(8'hC3, 1'b0);
    check("pair_second_flag", 9'(bus_if.dataIn[8]), 9'd0);
    check_all("pair_b");
    do_req();
    tick(599);
    check("pair_silence_low", 9'(bus_if.silence), 9'd0);
    tick(40);
    check("pair_silence_high", 9'(bus_if.silence), 9'd1);
    m_first = 1'b1;

    // Randomised characters, gaps and consumption
    for (int i = 0; i < 10; i++) begin
      rb    = 8'($urandom);
      rpb   = ($urandom_range(0, 3) == 0);
      rsb   = ($urandom_range(0, 5) == 0);
      rlong = ($urandom_range(0, 3) == 0);
      rcons = ($urandom_range(0, 2) != 0);
      if (rlong) begin
        tick(42 * BD);
        m_first = 1'b1;
      end else begin
        tick($urandom_range(4, BD));
      end
      send_char(rb, rpb, rsb);
      model_complete(rb, rpb | rsb);
      check_all("rand_char");
      if (rcons) begin
        do_req();
        check_all("rand_req");
      end
    end

    // Reset during DATA: outputs clear immediately, next character clean
    tick(8);
    send_char(8'h77, 1'b0, 1'b0);
    model_complete(8'h77, 1'b0);
    check_all("pre_reset_char");
    tick(4);
    bus_if.rx = 1'b0;
    tick(BD);
    bus_if.rx = 1'b1;
    tick(BD);
    bus_if.rx = 1'b0;
    tick(8);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    check("mid_reset_silence", 9'(bus_if.silence), 9'd0);
    bus_if.rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(SB * BD + 16);
    check("post_reset_silence", 9'(bus_if.silence), 9'd1);
    send_char(8'h9E, 1'b0, 1'b0);
    model_complete(8'h9E, 1'b0);
    check_all("post_reset_char");
    check("post_reset_value", bus_if.dataIn, 9'h19E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
